vsqrt_issue_ctrl: RTL

Initiator side of the sqrt unit handshake (input_val / valid_data_in / ready / valid_data_out / output_val). Accepts a masked vector of fp16 elements from the vector pipeline and streams active elements one at a time through the single, non-pipelined sqrt unit. Collects the results into a result vector and hands that vector back with a valid/ready handshake. A per-element timeout keeps a hung sqrt unit from stalling the lane.

---
 rtl/vsqrt_issue_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/vsqrt_issue_ctrl.sv
// Issue controller for a single non-pipelined fp16 sqrt unit: walks a masked
// vector one element at a time, collects results and returns the whole vector.
module vsqrt_issue_ctrl #(
  parameter int          NUM_ELEMS = 4,
  parameter int          TIMEOUT   = 64,
  parameter logic [15:0] NAN_VAL   = 16'h7E00
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [16*NUM_ELEMS-1:0]      in_vec,
  input  logic [NUM_ELEMS-1:0]         in_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [16*NUM_ELEMS-1:0]      out_vec,
  output logic                         timeout_err,
  output logic [15:0]                  sq_input_val,
  output logic                         sq_valid_data_in,
  input  logic                         sq_ready,
  input  logic                         sq_valid_data_out,
  input  logic [15:0]                  sq_output_val,
  output logic [$clog2(NUM_ELEMS)-1:0] elem_idx
);

  localparam int IDX_W = $clog2(NUM_ELEMS);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_ELEMS-1:0] mask_q;
  logic [15:0]          op_arr  [NUM_ELEMS];
  logic [15:0]          res_arr [NUM_ELEMS];
  logic                 last;

  assign last      = (idx == IDX_W'(NUM_ELEMS - 1));
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign elem_idx  = idx;

  // Result registers are the output vector; they are only written before DONE
  // so the vector stays stable while the consumer applies backpressure.
  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_out
    assign out_vec[16*g +: 16] = res_arr[g];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state            <= S_IDLE;
      idx              <= '0;
      cnt              <= '0;
      mask_q           <= '0;
      sq_input_val     <= '0;
      sq_valid_data_in <= 1'b0;
      timeout_err      <= 1'b0;
      for (int i = 0; i < NUM_ELEMS; i++) begin
        op_arr[i]  <= '0;
        res_arr[i] <= '0;
      end
    end else begin
      sq_valid_data_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
              op_arr[i]  <= in_vec[16*i +: 16];
              res_arr[i] <= '0;
            end
            mask_q      <= in_mask;
            timeout_err <= 1'b0;
            idx         <= '0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!mask_q[idx]) begin
            res_arr[idx] <= op_arr[idx];
            state        <= last ? S_DONE : S_ISSUE;
            if (!last) idx <= idx + IDX_W'(1);
          end else if (sq_ready) begin
            sq_input_val     <= op_arr[idx];
            sq_valid_data_in <= 1'b1;
            cnt              <= '0;
            state            <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A hung sqrt unit is replaced by NaN after TIMEOUT cycles.
          if (sq_valid_data_out) begin
            res_arr[idx] <= sq_output_val;
            state        <= last ? S_DONE : S_ISSUE;
            if (!last) idx <= idx + IDX_W'(1);
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            res_arr[idx] <= NAN_VAL;
            timeout_err  <= 1'b1;
            state        <= last ? S_DONE : S_ISSUE;
            if (!last) idx <= idx + IDX_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
